seq_div512: RTL and testbench

- Sequential restoring divider. It is the inverse companion to the 256x256 Karatsuba multiplier (ks256).
- It takes a 2*WIDTH-bit dividend (a product-width value) and a WIDTH-bit divisor, and returns the full quotient and remainder.
- It produces one quotient bit per clock and uses a start/busy/done handshake.
- Used to check multiplier results (prod / b == a, remainder 0) and for the reduction steps in the crypto datapath.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 33 +++
 rtl/seq_div512.sv | 140 ++++++++++++++
 tb/tb_seq_div512.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================
// div_pkg - shared types and constants for seq_div512
// Rev 1.0
// ============================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 256;
  localparam int DIV_DW    = 2 * DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================
// div_step - one combinational restoring-division step
// Rev 1.0
// ============================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  // The incoming remainder is always below the divisor, so its top bit is never set.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem_in[WIDTH];

  always_comb begin
    rem_shift = {rem_in[WIDTH-1:0], bit_in};
    rem_diff  = rem_shift - {1'b0, divisor};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_out   = q_bit ? rem_diff : rem_shift;
  end

endmodule

`default_nettype wire

// File: rtl/seq_div512.sv
// ============================================================
// seq_div512 - sequential restoring divider, one quotient bit per clock
// Rev 1.0
// ============================================================
`default_nettype none

module seq_div512
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int DW = 2 * WIDTH;

  state_e           state_q,     state_d;
  logic [DW-1:0]    shift_q,     shift_d;
  logic [WIDTH-1:0] divisor_q,   divisor_d;
  logic [WIDTH:0]   rem_q,       rem_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [DW-1:0]    quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shift_q[DW-1]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = dividend;
          divisor_d = divisor;
          rem_d     = '0;
          dbz_d     = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            quotient_d  = '1;
            remainder_d = dividend[WIDTH-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(DW - 1);
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        // Quotient bits enter at the LSB as the dividend bits leave at the MSB.
        shift_d = {shift_q[DW-2:0], step_q_bit};
        rem_d   = step_rem;
        if (cnt_q == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          quotient_d  = {shift_q[DW-2:0], step_q_bit};
          remainder_d = step_rem[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_div512.sv
// ============================================================
// tb_seq_div512 - randomized self-checking bench for seq_div512
// Rev 1.0
// ============================================================
`default_nettype none

module tb_seq_div512;

  localparam int W  = 256;
  localparam int DW = 512;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div512 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
    chk({tag, "_quot"}, quotient, '0);
    chk({tag, "_rem"},  DW'(remainder), '0);
    chk({tag, "_dbz"},  DW'(div_by_zero), '0);
  endtask

  // Called #1 after a rising edge. poke_at: edge index at which a competing start
  // is issued; rst_at: edge index at which reset is pulsed (aborts the operation).
  task automatic do_op(input logic [DW-1:0] dd, input logic [W-1:0] dv,
                       input int poke_at, input int rst_at);
    logic [DW-1:0] exp_q;
    logic [W-1:0]  exp_r;
    logic          exp_z;
    int            edges;
    int            busy_drops;
    bit            seen;

    if (dv == '0) begin
      exp_q = '1;
      exp_r = dd[W-1:0];
      exp_z = 1'b1;
    end else begin
      exp_q = dd / {{W{1'b0}}, dv};
      exp_r = W'(dd % {{W{1'b0}}, dv});
      exp_z = 1'b0;
    end

    start = 1'b1; dividend = dd; divisor = dv;
    edges = 0; busy_drops = 0; seen = 1'b0;
    while (!seen && edges < 700) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      dividend = rand512();
      divisor  = W'(rand512());
      if (edges == poke_at) start = 1'b1;
      if (edges == 1 && dv != '0) chk("dbz_cleared_on_start", DW'(div_by_zero), '0);
      if (edges == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_reset");
        repeat (3) begin
          @(posedge clk); #1;
          chk("no_done_in_reset", DW'(done), '0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_done_after_abort", DW'(done), '0);
        return;
      end
      if (done) seen = 1'b1;
      else if (dv != '0 && !busy) busy_drops++;
    end

    if (!seen) begin
      chk("done_timeout", '0, DW'(1));
      return;
    end
    chk("latency", DW'(edges), (dv == '0) ? DW'(1) : DW'(513));
    chk("busy_held", DW'(busy_drops), '0);
    chk("busy_low_at_done", DW'(busy), '0);
    chk("quotient", quotient, exp_q);
    chk("remainder", DW'(remainder), DW'(exp_r));
    chk("div_by_zero", DW'(div_by_zero), DW'(exp_z));
    @(posedge clk); #1;
    chk("done_one_cycle", DW'(done), '0);
    chk("quotient_hold", quotient, exp_q);
    chk("remainder_hold", DW'(remainder), DW'(exp_r));
    chk("dbz_hold", DW'(div_by_zero), DW'(exp_z));
  endtask

  initial begin
    logic [DW-1:0] dd;
    logic [W-1:0]  dv;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(DW'(30), W'(2), 0, 0);
    do_op(DW'(31), W'(2), 0, 0);
    do_op(DW'(5),  W'(7), 0, 0);
    do_op({DW{1'b1}}, {W{1'b1}}, 0, 0);
    do_op({DW{1'b1}}, W'(1), 0, 0);
    do_op(DW'(16'h1234), '0, 0, 0);
    do_op(DW'(30), W'(2), 0, 0);
    do_op(DW'(1000), W'(3), 100, 0);
    do_op(rand512(), W'(rand512()), 0, 200);
    do_op(DW'(30), W'(2), 0, 0);

    for (int i = 0; i < 8; i++) begin
      dd = rand512();
      dv = W'(rand512()) >> $urandom_range(0, W - 1);
      if (i == 3) dv = '0;
      if (i == 5) dd = dd >> W;
      do_op(dd, dv, (i % 2 == 0) ? int'($urandom_range(2, 500)) : 0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
